// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - request and result handshake bundle for alu_issue_unit
//
// Purpose: groups the request channel (decode/register-read stage -> unit) and
// the result channel (unit -> consumer) of alu_issue_unit.
// Ports (signals):
//   in_valid/in_ready        request handshake
//   alu_op, funct            decode fields selecting the ALU operation
//   op_a, op_b               operands
//   in_tag                   request tag, returned with the result
//   out_valid/out_ready      result handshake
//   out_res, out_zero        result value and zero flag
//   out_illegal, out_tag     undecodable-op flag and request tag
// Modports: master = requester/consumer side, slave = alu_issue_unit.

interface alu_issue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_res;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, alu_op, funct, op_a, op_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, alu_op, funct, op_a, op_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_illegal, out_tag
    );
endinterface

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - ALU front end: decode, operand registers, in-order result FIFO
//
// Purpose: accepts ALU requests, translates alu_op/funct into the 4-bit ALU
// control code, drives the external combinational ALU from registers, captures
// its result one cycle later and returns results in order through a FIFO.
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   bus (slave)              request and result handshakes, see alu_issue_if
//   alu_ctr                  registered ALU control code
//   alu_in1, alu_in2         registered ALU operands
//   alu_res, alu_zero        combinational ALU result and zero flag

module alu_issue_unit #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus,
    output logic [3:0]  alu_ctr,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_res,
    input  logic        alu_zero
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] CTR_AND = 4'b0000;
    localparam logic [3:0] CTR_OR  = 4'b0001;
    localparam logic [3:0] CTR_ADD = 4'b0010;
    localparam logic [3:0] CTR_SUB = 4'b0110;
    localparam logic [3:0] CTR_SLT = 4'b0111;
    localparam logic [3:0] CTR_NOR = 4'b1100;

    // Decode
    logic [3:0] dec_ctr;
    logic       dec_illegal;

    always_comb begin
        dec_ctr     = CTR_ADD;
        dec_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: dec_ctr = CTR_ADD;
            2'b01: dec_ctr = CTR_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: dec_ctr = CTR_ADD;
                    6'b100010: dec_ctr = CTR_SUB;
                    6'b100100: dec_ctr = CTR_AND;
                    6'b100101: dec_ctr = CTR_OR;
                    6'b101010: dec_ctr = CTR_SLT;
                    6'b100111: dec_ctr = CTR_NOR;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Exec stage and FIFO state
    logic             exec_v;
    logic             exec_ill;
    logic [TAG_W-1:0] exec_tag;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic [31:0]      mem_res  [DEPTH];
    logic             mem_zero [DEPTH];
    logic             mem_ill  [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    logic [AW+1:0]    occupancy;
    logic             accept;
    logic             push;
    logic             pop;
    logic             out_valid_i;
    logic [31:0]      exec_res;
    logic             exec_zero;

    // The in-flight exec slot counts against capacity so the push one cycle
    // later always has room; this keeps in_ready off in_valid/out_ready.
    assign occupancy   = {1'b0, count} + {{(AW+1){1'b0}}, exec_v};
    assign bus.in_ready = occupancy < (AW+2)'(DEPTH);
    assign accept      = bus.in_valid && bus.in_ready;
    assign out_valid_i = count != '0;
    assign push        = exec_v;
    assign pop         = out_valid_i && bus.out_ready;

    // The ALU's own zero flag is only meaningful for subtract.
    assign exec_res  = exec_ill ? 32'd0 : alu_res;
    assign exec_zero = exec_ill ? 1'b1
                     : (alu_ctr == CTR_SUB) ? alu_zero
                     : (alu_res == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctr  <= 4'b0000;
            alu_in1  <= 32'd0;
            alu_in2  <= 32'd0;
            exec_v   <= 1'b0;
            exec_ill <= 1'b0;
            exec_tag <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            exec_v <= accept;
            if (accept) begin
                alu_in1  <= bus.op_a;
                alu_in2  <= bus.op_b;
                exec_ill <= dec_illegal;
                exec_tag <= bus.in_tag;
                // Illegal requests keep the previous code so the ALU repeats a benign op.
                if (!dec_illegal) begin
                    alu_ctr <= dec_ctr;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr]  <= exec_res;
            mem_zero[wr_ptr] <= exec_zero;
            mem_ill[wr_ptr]  <= exec_ill;
            mem_tag[wr_ptr]  <= exec_tag;
        end
    end

    // Outputs read zero while empty so reset leaves them cleared.
    assign bus.out_valid   = out_valid_i;
    assign bus.out_res     = out_valid_i ? mem_res[rd_ptr]  : 32'd0;
    assign bus.out_zero    = out_valid_i ? mem_zero[rd_ptr] : 1'b0;
    assign bus.out_illegal = out_valid_i ? mem_ill[rd_ptr]  : 1'b0;
    assign bus.out_tag     = out_valid_i ? mem_tag[rd_ptr]  : '0;
endmodule
